// File: rtl/router_egress_fifo.sv
// Egress FIFO between a router output port and its sink, with first-word fall-through head.
// Define ROUTER_EGRESS_STATS_EN to add the saturating pkt_count pop counter.
module router_egress_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic [DATA_W-1:0]      in_data,
  output logic                   in_ready,
  output logic                   out_valid,
  output logic [DATA_W-1:0]      out_data,
  input  logic                   out_ready,
  output logic [$clog2(DEPTH):0] count,
  output logic                   drop_err
`ifdef ROUTER_EGRESS_STATS_EN
  ,
  output logic [15:0]            pkt_count
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              push;
  logic              pop;

  // Handshake flags come only from registered occupancy, so out_ready never reaches in_ready.
  assign in_ready  = (count < FULL_COUNT);
  assign out_valid = (count != '0);
  assign out_data  = mem[rd_ptr];
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= in_data;
    end
  end

  // Pointers wrap by natural overflow because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      drop_err <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (in_valid && !in_ready) begin
        drop_err <= 1'b1;
      end
    end
  end

`ifdef ROUTER_EGRESS_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pkt_count <= '0;
    end else if (pop && (pkt_count != 16'hFFFF)) begin
      pkt_count <= pkt_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_router_egress_fifo.sv
// Directed bench for router_egress_fifo; expected head data is queued at stimulus time
// and a separate monitor compares it whenever the sink accepts an entry.
module tb_router_egress_fifo;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 8;
  localparam int CW     = $clog2(DEPTH) + 1;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic [DATA_W-1:0] in_data = '0;
  logic              out_ready = 1'b0;
  logic              in_ready;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic [CW-1:0]     count;
  logic              drop_err;
`ifdef ROUTER_EGRESS_STATS_EN
  logic [15:0]       pkt_count;
`endif

  int checks = 0;
  int errors = 0;
  logic [DATA_W-1:0] exp_q[$];

  router_egress_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .count     (count),
    .drop_err  (drop_err)
`ifdef ROUTER_EGRESS_STATS_EN
    ,
    .pkt_count (pkt_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  // Drive one cycle of inputs just after an edge and return just after the next edge.
  task automatic apply_stimulus(input logic v, input logic [DATA_W-1:0] d, input logic r, input logic accept);
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    if (v && accept) exp_q.push_back(d);
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare every accepted head entry against the scoreboard queue.
  always @(negedge clk) begin
    if (rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL pop_unexpected actual=%0h expected=none", out_data);
      end else begin
        check_output("out_data", 32'(out_data), 32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    // Power-on reset, checked before any clock edge.
    #1 rst = 1'b0;
    #2;
    check_output("rst_count", 32'(count), 0);
    check_output("rst_out_valid", 32'(out_valid), 0);
    check_output("rst_in_ready", 32'(in_ready), 1);
    check_output("rst_drop_err", 32'(drop_err), 0);
    @(posedge clk);
    #1 rst = 1'b1;

    // Push into empty FIFO: no same-cycle bypass, visible one edge later.
    in_valid = 1'b1;
    in_data  = 8'hC1;
    exp_q.push_back(8'hC1);
    #2;
    check_output("no_bypass", 32'(out_valid), 0);
    @(posedge clk);
    #1;
    check_output("lat_out_valid", 32'(out_valid), 1);
    check_output("lat_count", 32'(count), 1);
    apply_stimulus(1'b0, 8'h00, 1'b1, 1'b0);
    check_output("pop_count", 32'(count), 0);
    apply_stimulus(1'b0, 8'h00, 1'b1, 1'b0);
    check_output("empty_pop_count", 32'(count), 0);
    check_output("empty_pop_valid", 32'(out_valid), 0);

    // Fill A1..A8 with the sink stalled.
    for (int i = 0; i < DEPTH; i++) apply_stimulus(1'b1, 8'(8'hA1 + i), 1'b0, 1'b1);
    check_output("full_count", 32'(count), 8);
    check_output("full_in_ready", 32'(in_ready), 0);
    check_output("full_head", 32'(out_data), 32'hA1);
    apply_stimulus(1'b0, 8'h00, 1'b0, 1'b0);
    check_output("hold_head", 32'(out_data), 32'hA1);

    // Overflow attempt: FF must be dropped and flagged.
    apply_stimulus(1'b1, 8'hFF, 1'b0, 1'b0);
    check_output("ovf_drop_err", 32'(drop_err), 1);
    check_output("ovf_count", 32'(count), 8);
    apply_stimulus(1'b0, 8'h00, 1'b0, 1'b0);
    check_output("drop_err_sticky", 32'(drop_err), 1);

    // Drain; the first cycle also offers EE while full, which must be ignored.
    apply_stimulus(1'b1, 8'hEE, 1'b1, 1'b0);
    check_output("full_pop_count", 32'(count), 7);
    for (int i = 1; i < DEPTH; i++) apply_stimulus(1'b0, 8'h00, 1'b1, 1'b0);
    check_output("drain_count", 32'(count), 0);
    check_output("drain_out_valid", 32'(out_valid), 0);
    check_output("drain_in_ready", 32'(in_ready), 1);

    // Concurrent push/pop at occupancy 3, wrapping both pointers.
    for (int i = 0; i < 3; i++) apply_stimulus(1'b1, 8'(8'hD1 + i), 1'b0, 1'b1);
    check_output("conc_pre_count", 32'(count), 3);
    for (int i = 0; i < 10; i++) begin
      apply_stimulus(1'b1, 8'(8'hB0 + i), 1'b1, 1'b1);
      check_output("conc_count", 32'(count), 3);
    end
    for (int i = 0; i < 10 && count != 0; i++) apply_stimulus(1'b0, 8'h00, 1'b1, 1'b0);
    check_output("conc_drain_count", 32'(count), 0);
    check_output("sb_empty", 32'(exp_q.size()), 0);

    // Reset mid-traffic with five entries stored.
    for (int i = 0; i < 5; i++) apply_stimulus(1'b1, 8'(8'h50 + i), 1'b0, 1'b1);
    check_output("pre_rst_count", 32'(count), 5);
    #2 rst = 1'b0;
    #1;
    check_output("mid_rst_count", 32'(count), 0);
    check_output("mid_rst_out_valid", 32'(out_valid), 0);
    check_output("mid_rst_drop_err", 32'(drop_err), 0);
    check_output("mid_rst_in_ready", 32'(in_ready), 1);
    exp_q.delete();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    @(posedge clk);
    #2 rst = 1'b1;
    @(posedge clk);
    #1;
    apply_stimulus(1'b1, 8'hE1, 1'b0, 1'b1);
    check_output("resume_count", 32'(count), 1);
    check_output("resume_head", 32'(out_data), 32'hE1);
    apply_stimulus(1'b0, 8'h00, 1'b1, 1'b0);
    check_output("resume_pop_count", 32'(count), 0);

`ifdef ROUTER_EGRESS_STATS_EN
    check_output("pkt_count_1", 32'(pkt_count), 1);
    for (int i = 0; i < 4; i++) apply_stimulus(1'b1, 8'(8'h60 + i), 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) apply_stimulus(1'b0, 8'h00, 1'b1, 1'b0);
    check_output("pkt_count_5", 32'(pkt_count), 5);
    apply_stimulus(1'b1, 8'h70, 1'b0, 1'b1);
    for (int i = 0; i < 65535; i++) apply_stimulus(1'b1, 8'(i), 1'b1, 1'b1);
    check_output("pkt_count_sat", 32'(pkt_count), 32'hFFFF);
    apply_stimulus(1'b0, 8'h00, 1'b1, 1'b0);
    check_output("pkt_count_hold", 32'(pkt_count), 32'hFFFF);
`endif

    apply_stimulus(1'b0, 8'h00, 1'b0, 1'b0);
    check_output("final_sb_empty", 32'(exp_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/router_egress_fifo.md
ROUTER_EGRESS_FIFO -- requirements
Module: router_egress_fifo

Interface
REQ-001 SHALL have parameter DATA_W, default 8, width of data path (matches router data_outN).
REQ-002 SHALL have parameter DEPTH, default 8, number of entries; power of two, 2..256.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port in_valid  input  1  upstream byte valid (router valid_out[n]).
REQ-006 SHALL have port in_data  input  DATA_W  upstream byte (router data_outN).
REQ-007 SHALL have port in_ready  output  1  space available (drives router ready_out[n]).
REQ-008 SHALL have port out_valid  output  1  head entry valid to sink.
REQ-009 SHALL have port out_data  output  DATA_W  head entry data.
REQ-010 SHALL have port out_ready  input  1  sink accepts head entry.
REQ-011 SHALL have port count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
REQ-012 SHALL have port drop_err  output  1  sticky flag: in_valid seen while in_ready low.

Function
REQ-013 SHALL write in_data at rising edge when in_valid=1 and in_ready=1 (push).
REQ-014 SHALL pop head entry at rising edge when out_valid=1 and out_ready=1.
REQ-015 SHALL drive in_ready = (count < DEPTH), decoded only from registered count (no combinational path from out_ready).
REQ-016 SHALL drive out_valid = (count != 0) and out_data = entry at read pointer (first-word fall-through).
REQ-017 SHALL give push-to-out_valid latency of exactly 1 cycle when empty; no same-cycle bypass.
REQ-018 SHALL, on simultaneous push and pop, keep count unchanged and advance both pointers.
REQ-019 SHALL, when full, ignore in_valid even if a pop occurs that cycle (in_ready already 0); data is not stored.
REQ-020 SHALL, on in_valid=1 with in_ready=0, set drop_err=1; drop_err holds until reset.
REQ-021 SHALL wrap read/write pointers modulo DEPTH; DEPTH is a power of two so wrap is natural overflow.
REQ-022 SHALL, when empty with out_ready=1 and no push, not change pointers or count.
REQ-023 SHALL hold out_data stable while out_valid=1 and out_ready=0.
REQ-024 SHALL keep storage array unreset; only pointers, count, flags are reset.

Reset
REQ-025 SHALL, while rst=0, force immediately: count=0, out_valid=0, in_ready=1 (after release, count<DEPTH), drop_err=0, pointers=0.
REQ-026 SHALL, on rst asserted mid-operation, discard all stored entries; no pop/push completes in that cycle.
REQ-027 SHALL resume normal push/pop on the first rising edge after rst returns to 1.

Configuration
REQ-028 SHALL, with macro ROUTER_EGRESS_STATS_EN defined, add output pkt_count (16 bits) counting completed pops, saturating at 16'hFFFF, reset to 0.
REQ-029 SHALL, without ROUTER_EGRESS_STATS_EN, omit pkt_count port and its counter entirely; all other behaviour identical.

Verification
REQ-030 Reset: rst=0 mid-traffic with count=5 -> count=0, out_valid=0, drop_err=0 immediately; after release in_ready=1.
REQ-031 Fill: out_ready=0, push A1..A8 on 8 consecutive cycles -> count=8, in_ready=0 after 8th edge; out_data=A1 held.
REQ-032 Overflow: full, in_valid=1 with data FF for 1 cycle -> drop_err=1 and stays 1; count=8; FF never appears on out_data.
REQ-033 Drain/order: from full, out_ready=1 for 8 cycles -> out_data sequence A1..A8, then out_valid=0, count=0.
REQ-034 Concurrent: count=3, push B2 and pop same cycle for 10 cycles -> count stays 3, pointers wrap past DEPTH, order preserved.
REQ-035 Stats (ROUTER_EGRESS_STATS_EN): 5 pops -> pkt_count=5; preload via 65535 pops then 1 more -> pkt_count=16'hFFFF.
